// File: rtl/covox_sd_dac.sv
// Covox output stage: Z80 OUT #FB decode feeding a first-order sigma-delta modulator.
// Define COVOX_FIFO_EN to add the paced sample FIFO; otherwise writes load the sample directly.
module covox_sd_dac #(
    parameter int unsigned RATE_DIV    = 80,
    parameter int unsigned FIFO_AW     = 2,
    parameter logic [7:0]  IDLE_SAMPLE = 8'h80
) (
    input  logic       cpu_clock,
    input  logic       reset,
    input  logic       iorq,
    input  logic       wr,
    input  logic       m1,
    input  logic       a2,
    input  logic [7:0] d,
    output logic       covox,
    output logic       fifo_empty,
    output logic       fifo_full,
    output logic       overflow
);

    logic       wr_act;
    logic       wr_act_q;
    logic       push;
    logic [7:0] acc;
    logic [7:0] held;
    logic [8:0] mod_sum;

    // Rising edge of the decoded write gives one push per OUT, however long /WR is stretched.
    assign wr_act  = !iorq && !wr && m1 && !a2;
    assign push    = wr_act && !wr_act_q;
    assign mod_sum = {1'b0, acc} + {1'b0, held};

    always_ff @(posedge cpu_clock or posedge reset) begin
        if (reset) begin
            wr_act_q <= 1'b0;
            acc      <= 8'h00;
            covox    <= 1'b0;
        end else begin
            wr_act_q <= wr_act;
            acc      <= mod_sum[7:0];
            covox    <= mod_sum[8];
        end
    end

`ifdef COVOX_FIFO_EN
    localparam int unsigned         DEPTH    = 1 << FIFO_AW;
    localparam logic [7:0]          PACE_MAX = 8'(RATE_DIV - 1);
    localparam logic [FIFO_AW:0]    CNT_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]    CNT_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0]  PTR_ONE  = FIFO_AW'(1);

    logic [7:0]         mem [DEPTH];
    logic [7:0]         pace;
    logic               tick;
    logic [FIFO_AW-1:0] wptr;
    logic [FIFO_AW-1:0] rptr;
    logic [FIFO_AW:0]   count;
    logic [FIFO_AW:0]   count_nxt;
    logic               do_pop;
    logic               do_push;

    // A pop frees a slot on the same edge, so a full FIFO still accepts a push coincident with a tick.
    assign tick    = (pace == PACE_MAX);
    assign do_pop  = tick && (count != '0);
    assign do_push = push && ((count != CNT_FULL) || do_pop);

    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge cpu_clock or posedge reset) begin
        if (reset) begin
            pace       <= 8'd0;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            held       <= IDLE_SAMPLE;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            pace <= tick ? 8'd0 : pace + 8'd1;
            if (do_pop) begin
                held <= mem[rptr];
                rptr <= rptr + PTR_ONE;
            end
            if (do_push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
            count      <= count_nxt;
            fifo_empty <= (count_nxt == '0);
            fifo_full  <= (count_nxt == CNT_FULL);
        end
    end

    // Sample storage carries no control meaning, so it is left out of reset.
    always_ff @(posedge cpu_clock) begin
        if (do_push) begin
            mem[wptr] <= d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{RATE_DIV, FIFO_AW};

    assign fifo_empty = 1'b1;
    assign fifo_full  = 1'b0;
    assign overflow   = 1'b0;

    always_ff @(posedge cpu_clock or posedge reset) begin
        if (reset) begin
            held <= IDLE_SAMPLE;
        end else if (push) begin
            held <= d;
        end
    end
`endif

endmodule

// File: tb/tb_covox_sd_dac.sv
// Testbench for covox_sd_dac: sample-level reference model checked every cycle plus directed literal checks.
// Follows COVOX_FIFO_EN the same way as the design.
module tb_covox_sd_dac;
    localparam int RATE_DIV = 64;
    localparam int FIFO_AW  = 2;
    localparam int DEPTH    = 1 << FIFO_AW;

    logic       clk = 1'b0;
    logic       reset;
    logic       iorq, wr, m1, a2;
    logic [7:0] d;
    logic       covox, fifo_empty, fifo_full, overflow;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    covox_sd_dac #(.RATE_DIV(RATE_DIV), .FIFO_AW(FIFO_AW), .IDLE_SAMPLE(8'h80)) dut (
        .cpu_clock (clk),
        .reset     (reset),
        .iorq      (iorq),
        .wr        (wr),
        .m1        (m1),
        .a2        (a2),
        .d         (d),
        .covox     (covox),
        .fifo_empty(fifo_empty),
        .fifo_full (fifo_full),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: running phase accumulator, held sample, sample queue and playback tick count.
    int         m_acc, m_held, m_pace, m_sum;
    bit         m_cov, m_prev, m_ovf, m_act, m_push, m_tick;
    logic [7:0] q[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_acc  = 0;
            m_held = 8'h80;
            m_cov  = 1'b0;
            m_prev = 1'b0;
            m_ovf  = 1'b0;
            m_pace = 0;
            q.delete();
        end else begin
            m_sum  = m_acc + m_held;
            m_cov  = (m_sum > 255);
            m_acc  = m_sum % 256;
            m_act  = (iorq == 1'b0) && (wr == 1'b0) && (m1 == 1'b1) && (a2 == 1'b0);
            m_push = m_act && !m_prev;
            m_prev = m_act;
`ifdef COVOX_FIFO_EN
            m_tick = (m_pace == RATE_DIV - 1);
            m_pace = m_tick ? 0 : m_pace + 1;
            if (m_tick && q.size() > 0) m_held = q.pop_front();
            if (m_push) begin
                if (q.size() < DEPTH) q.push_back(d);
                else m_ovf = 1'b1;
            end
`else
            if (m_push) m_held = d;
`endif
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_covox", 32'(covox), 32'(m_cov));
            check("model_fifo_empty", 32'(fifo_empty), 32'(q.size() == 0));
            check("model_fifo_full", 32'(fifo_full), 32'(q.size() == DEPTH));
            check("model_overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    task automatic idle_bus();
        iorq = 1'b1; wr = 1'b1; m1 = 1'b1; a2 = 1'b0; d = 8'h00;
    endtask

    // One bus cycle with /IORQ,/WR low for low_cycles clocks; data switches to 'later' after the first.
    task automatic out_cycle(input logic [7:0] val, input logic a2v, input logic m1v,
                             input int low_cycles, input logic [7:0] later);
        @(negedge clk);
        iorq = 1'b0; wr = 1'b0; m1 = m1v; a2 = a2v; d = val;
        @(negedge clk);
        d = later;
        repeat (low_cycles - 1) @(negedge clk);
        idle_bus();
    endtask

    task automatic count_ones(input int n, output int ones);
        ones = 0;
        repeat (n) begin
            @(negedge clk);
            ones += int'(covox);
        end
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_pace != 0 && n < 2 * RATE_DIV + 2);
        if (m_pace != 0) begin
            checks++;
            errors++;
            $display("FAIL wait_tick: got timeout expected tick within %0d cycles", 2 * RATE_DIV + 2);
        end
    endtask

    task automatic check_idle_pattern(input string name);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check(name, 32'(covox), 32'(i % 2));
        end
    endtask

    int ones;

    initial begin
        idle_bus();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        check("rst_covox", 32'(covox), 32'd0);
        check("rst_fifo_empty", 32'(fifo_empty), 32'd1);
        check("rst_fifo_full", 32'(fifo_full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        check_idle_pattern("post_rst_seq");

`ifndef COVOX_FIFO_EN
        out_cycle(8'h00, 1'b1, 1'b1, 1, 8'h00);
        count_ones(16, ones);
        check("a2_high_ignored", 32'(ones), 32'd8);

        out_cycle(8'h00, 1'b0, 1'b0, 1, 8'h00);
        count_ones(16, ones);
        check("inta_ignored", 32'(ones), 32'd8);

        out_cycle(8'h00, 1'b0, 1'b1, 5, 8'hFF);
        count_ones(64, ones);
        check("wait_state_single_push", 32'(ones), 32'd0);

        out_cycle(8'hFF, 1'b0, 1'b1, 1, 8'hFF);
        repeat (2) @(negedge clk);
        count_ones(256, ones);
        check("ff_one_zero_per_256", 32'(ones), 32'd255);

        out_cycle(8'h00, 1'b0, 1'b1, 1, 8'h00);
        count_ones(20, ones);
        check("zero_sample_silent", 32'(ones), 32'd0);

        out_cycle(8'hFF, 1'b0, 1'b1, 1, 8'hFF);
        repeat (10) @(negedge clk);
`else
        wait_tick();
        out_cycle(8'h11, 1'b0, 1'b1, 1, 8'h11);
        out_cycle(8'h22, 1'b0, 1'b1, 1, 8'h22);
        out_cycle(8'h33, 1'b0, 1'b1, 1, 8'h33);
        check("full_after_4_empty", 32'(fifo_empty), 32'd0);
        out_cycle(8'h44, 1'b0, 1'b1, 1, 8'h44);
        check("full_after_4", 32'(fifo_full), 32'd1);
        check("no_ovf_after_4", 32'(overflow), 32'd0);
        out_cycle(8'h55, 1'b0, 1'b1, 1, 8'h55);
        check("ovf_after_5", 32'(overflow), 32'd1);
        check("still_full_after_5", 32'(fifo_full), 32'd1);
        repeat (5) wait_tick();
        check("drained_empty", 32'(fifo_empty), 32'd1);
        check("ovf_sticky", 32'(overflow), 32'd1);
        @(negedge clk);
        count_ones(256, ones);
        check("held_stays_44", 32'(ones), 32'h44);

        out_cycle(8'hFF, 1'b0, 1'b1, 1, 8'hFF);
        wait_tick();
        @(negedge clk);
        count_ones(256, ones);
        check("fifo_ff_one_zero", 32'(ones), 32'd255);

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_tick();
        out_cycle(8'hA1, 1'b0, 1'b1, 1, 8'hA1);
        out_cycle(8'hA2, 1'b0, 1'b1, 1, 8'hA2);
        out_cycle(8'hA3, 1'b0, 1'b1, 1, 8'hA3);
        out_cycle(8'hA4, 1'b0, 1'b1, 1, 8'hA4);
        for (int n = 0; n < 2 * RATE_DIV && m_pace != RATE_DIV - 2; n++) @(negedge clk);
        check("align_to_tick", 32'(m_pace), 32'(RATE_DIV - 2));
        out_cycle(8'hA5, 1'b0, 1'b1, 1, 8'hA5);
        check("push_pop_full_kept", 32'(fifo_full), 32'd1);
        check("push_pop_no_ovf", 32'(overflow), 32'd0);
        repeat (5) wait_tick();
        check("coincident_drained", 32'(fifo_empty), 32'd1);
        @(negedge clk);
        count_ones(256, ones);
        check("last_queued_a5", 32'(ones), 32'hA5);
`endif

        // Asynchronous 10 ns reset pulse straddling a rising edge.
        @(negedge clk);
        #2 reset = 1'b1;
        #2;
        check("async_rst_covox", 32'(covox), 32'd0);
        check("async_rst_empty", 32'(fifo_empty), 32'd1);
        check("async_rst_full", 32'(fifo_full), 32'd0);
        check("async_rst_ovf", 32'(overflow), 32'd0);
        #8 reset = 1'b0;
        check_idle_pattern("midrun_rst_seq");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
